btn_debouncer: RTL and testbench
================================

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter: N, default 19, width of the debounce interval counter; stable interval = 2^N clock cycles.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: sw  input  1  raw, bouncing, asynchronous pushbutton/switch level.
REQ-005 Port: db_level  output  1  debounced level, registered.
REQ-006 Port: db_tick  output  1  one-cycle pulse on each debounced rising transition, registered; drives the counter's en/load/syn_clr inputs.
REQ-007 Port: db_fall_tick  output  1  one-cycle pulse on each debounced falling transition; present only per REQ-024.

Function
REQ-008 sw SHALL pass through a 2-flop synchronizer (sync1, sync2); the FSM SHALL use only sw_s = sync2.
REQ-009 FSM states SHALL be ZERO, WAIT1, ONE, WAIT0; N-bit down-counter cnt.
REQ-010 ZERO: sw_s=1 -> WAIT1, cnt <= 2^N-1; else stay.
REQ-011 WAIT1: sw_s=0 -> ZERO (bounce rejected, no pulse); sw_s=1 and cnt!=0 -> cnt <= cnt-1; sw_s=1 and cnt==0 -> ONE.
REQ-012 ONE: sw_s=0 -> WAIT0, cnt <= 2^N-1; else stay.
REQ-013 WAIT0: sw_s=1 -> ONE (no pulse); sw_s=0 and cnt!=0 -> cnt <= cnt-1; sw_s=0 and cnt==0 -> ZERO.
REQ-014 db_level SHALL be 1 exactly when state is ONE or WAIT0.
REQ-015 db_tick SHALL be 1 for exactly the one cycle following the clock edge on which WAIT1 -> ONE is taken; 0 otherwise.
REQ-016 Latency: if sw goes high before edge k and stays high, db_level and db_tick SHALL assert after edge k+2^N+2; falling path symmetric.
REQ-017 Any sw_s glitch shorter than the full interval in WAIT1/WAIT0 SHALL return to the prior stable state and restart the full interval on the next change.
REQ-018 cnt SHALL never wrap below 0; at cnt==0 it holds until the state changes.
REQ-019 Back-to-back pulses SHALL be separated by at least 2*(2^N+1) cycles (full high + full low interval).

Reset
REQ-020 reset=0 SHALL asynchronously force state=ZERO, cnt=0, sync1=sync2=0, db_level=0, db_tick=0, db_fall_tick=0.
REQ-021 Reset asserted mid-WAIT1/WAIT0 SHALL abort the interval with no pulse emitted.
REQ-022 After reset release with sw held high, the block SHALL treat it as a fresh rising transition (db_tick fires once per REQ-016).

Configuration
REQ-023 Macro BTN_DEBOUNCER_FALL_TICK_EN controls the falling-edge pulse.
REQ-024 Defined: port db_fall_tick exists and is 1 for exactly the one cycle following the WAIT0 -> ZERO edge.
REQ-025 Undefined: port db_fall_tick and its register are absent; all other behaviour identical.

Verification (run with N=3, interval 8 cycles)
REQ-026 Reset low, sw=1 -> all outputs 0; release reset with sw=1 -> db_level=1, db_tick single pulse after edge 10 counted from the first post-release edge.
REQ-027 sw clean 0->1 held 20 cycles -> db_level rises after edge k+10, db_tick high exactly 1 cycle, db_level stays 1.
REQ-028 sw bounces 1,0,1,0 every 3 cycles then stable 1 -> no db_tick during bounce; exactly one db_tick 10 edges after last rise.
REQ-029 db_level=1, sw low for 5 cycles then high -> db_level stays 1, no pulses; with macro defined, db_fall_tick stays 0.
REQ-030 Macro defined, sw 1->0 held 20 cycles -> db_level falls after edge k+10, db_fall_tick high exactly 1 cycle, db_tick 0.
REQ-031 Reset asserted at cycle 4 of WAIT1 -> outputs 0 immediately, no db_tick after release while sw=0.

Source files
------------

// File: rtl/btn_debouncer.sv
// btn_debouncer: pushbutton/switch debouncer.
//
// The raw switch level is synchronised through two flops, then a four-state
// FSM (ZERO, WAIT1, ONE, WAIT0) requires the synchronised level to hold for
// a full interval of the N-bit down-counter before the debounced level
// changes. A registered one-cycle pulse marks each debounced rising edge.
//
// Optional feature (define BTN_DEBOUNCER_FALL_TICK_EN to enable):
//   adds output db_fall_tick, a registered one-cycle pulse on each
//   debounced falling edge. With the macro undefined the port and its
//   register do not exist and all other behaviour is unchanged.
//
// dbg_state exposes the current FSM state encoding for observation:
//   0 = ZERO, 1 = WAIT1, 2 = ONE, 3 = WAIT0.
//
// No valid/ready handshakes: sw is a free-running level input and all
// outputs are free-running registered levels/pulses.

module btn_debouncer #(
  parameter int N = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  output logic       db_level,
  output logic       db_tick,
  output logic [1:0] dbg_state
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
  ,
  output logic       db_fall_tick
`endif
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // Reload value: the counter runs 2^N-1 down to 0, then one more edge to
  // commit, so a change must be seen for 2^N+1 consecutive samples.
  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic         sync1;
  logic         sync2;
  logic         sw_s;
  state_t       state;
  state_t       state_next;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_next;
  logic         level_next;
  logic         tick_next;

  // Two-flop synchroniser for the asynchronous switch level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  assign sw_s = sync2;

  // State and interval counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic; the counter holds at zero rather than
  // wrapping, and any opposite sample aborts the pending interval.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = CNT_MAX;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else begin
          state_next = ONE;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = CNT_MAX;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else begin
          state_next = ZERO;
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line
  // up with the state they describe.
  always_comb begin
    level_next = (state_next == ONE) || (state_next == WAIT0);
    tick_next  = (state == WAIT1) && (state_next == ONE);
  end

  // Registered debounced level and rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_level <= level_next;
      db_tick  <= tick_next;
    end
  end

`ifdef BTN_DEBOUNCER_FALL_TICK_EN
  logic fall_next;

  // Falling-edge pulse decode: only a completed WAIT0 interval counts.
  always_comb begin
    fall_next = (state == WAIT0) && (state_next == ZERO);
  end

  // Registered falling-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_fall_tick <= 1'b0;
    end else begin
      db_fall_tick <= fall_next;
    end
  end

  a_fall_low : assert property (@(posedge clk) disable iff (!reset)
    db_fall_tick |-> !db_level);
`else
`endif

  assign dbg_state = state;

  a_tick_high : assert property (@(posedge clk) disable iff (!reset)
    db_tick |-> db_level);

endmodule

// File: tb/tb_btn_debouncer.sv
// Testbench for btn_debouncer with N=3 (interval of 8 counts).
// Checks every cycle against a run-length reference model through an
// expected queue, plus per-segment hand-derived expectations and a few
// hand-written reset sequences.

module tb_btn_debouncer;

  localparam int N       = 3;
  localparam int RUN_LEN = (1 << N) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw;
  logic       db_level;
  logic       db_tick;
  logic [1:0] dbg_state;
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
  logic       db_fall_tick;
`endif

  btn_debouncer #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .db_level     (db_level),
    .db_tick      (db_tick),
    .dbg_state    (dbg_state)
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
    ,
    .db_fall_tick (db_fall_tick)
`endif
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  typedef struct {
    logic sw;
    int   cycles;
    logic exp_level;
    int   exp_rise;
    int   exp_fall;
  } vec_t;

  vec_t       vecs [12];
  logic [2:0] exp_q [$];   // {level, rise tick, fall tick}
  int         checks = 0;
  int         errors = 0;

  // Reference model: run length of synchronised samples opposite to level.
  logic m_s1, m_s2, m_level;
  int   m_run;
  int   obs_rise, obs_fall, edge_no, tick_edge;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1    = 1'b0;
    m_s2    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
  endtask

  task automatic model_edge(input logic sw_now, output logic [2:0] e);
    logic rise;
    logic fall;
    rise = 1'b0;
    fall = 1'b0;
    if (m_s2 != m_level) begin
      m_run++;
      if (m_run == RUN_LEN) begin
        m_level = ~m_level;
        rise    = m_level;
        fall    = ~m_level;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = sw_now;
    e = {m_level, rise, fall};
  endtask

  // Driver: apply sw at the falling edge, push the model's expectation,
  // then pop and compare just after the rising edge.
  task automatic step(input logic v);
    logic [2:0] e;
    logic [2:0] got;
    @(negedge clk);
    sw = v;
    if (reset) model_edge(v, e);
    else       e = 3'b000;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    edge_no++;
    check_bit($sformatf("sb_level@%0t", $time), db_level, got[2]);
    check_bit($sformatf("sb_tick@%0t", $time), db_tick, got[1]);
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
    check_bit($sformatf("sb_fall@%0t", $time), db_fall_tick, got[0]);
    obs_fall += int'(db_fall_tick);
`endif
    obs_rise += int'(db_tick);
    if (db_tick && tick_edge < 0) tick_edge = edge_no;
  endtask

  // Called just after a step: drops reset mid-cycle and checks that the
  // outputs clear without waiting for a clock edge.
  task automatic async_reset_check(input string name);
    #2;
    reset = 1'b0;
    #1;
    check_bit({name, "_level"}, db_level, 1'b0);
    check_bit({name, "_tick"}, db_tick, 1'b0);
    check_int({name, "_state"}, int'(dbg_state), 0);
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
    check_bit({name, "_fall"}, db_fall_tick, 1'b0);
`endif
    model_reset();
  endtask

  // Called just after a step: releases reset before the next falling edge.
  task automatic release_reset();
    #2;
    reset = 1'b1;
    obs_rise  = 0;
    obs_fall  = 0;
    edge_no   = 0;
    tick_edge = -1;
  endtask

  initial begin
    // {sw, cycles, level at end, rising ticks, falling ticks} starting from
    // a settled level 1 with sw high.
    vecs[0]  = '{1'b0,  5, 1'b1, 0, 0};  // short low glitch rejected
    vecs[1]  = '{1'b1, 12, 1'b1, 0, 0};
    vecs[2]  = '{1'b0, 20, 1'b0, 0, 1};  // clean fall
    vecs[3]  = '{1'b1,  3, 1'b0, 0, 0};  // bounce 1,0,1,0 every 3 cycles
    vecs[4]  = '{1'b0,  3, 1'b0, 0, 0};
    vecs[5]  = '{1'b1,  3, 1'b0, 0, 0};
    vecs[6]  = '{1'b0,  3, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 20, 1'b1, 1, 0};  // settles high: one tick
    vecs[8]  = '{1'b0,  8, 1'b1, 0, 0};  // one sample short of the interval
    vecs[9]  = '{1'b1, 12, 1'b1, 0, 0};
    vecs[10] = '{1'b0,  9, 1'b1, 0, 0};  // exactly the interval; fall lands later
    vecs[11] = '{1'b1, 20, 1'b1, 1, 1};  // late fall, then a fresh rise

    model_reset();
    obs_rise  = 0;
    obs_fall  = 0;
    edge_no   = 0;
    tick_edge = -1;

    // Reset held low with sw high: everything stays cleared.
    reset = 1'b0;
    sw    = 1'b1;
    #1;
    check_bit("por_level", db_level, 1'b0);
    check_bit("por_tick", db_tick, 1'b0);
    check_int("por_state", int'(dbg_state), 0);
    repeat (3) step(1'b1);
    check_int("por_no_tick", obs_rise, 0);

    // Release with sw high: fresh rising transition. With the first
    // post-release edge numbered 1, the tick follows edge 11 (k+2^N+2).
    release_reset();
    repeat (25) step(1'b1);
    check_int("rel_tick_edge", tick_edge, 11);
    check_int("rel_tick_count", obs_rise, 1);
    check_bit("rel_level", db_level, 1'b1);

    // Table-driven segments.
    for (int i = 0; i < 12; i++) begin
      obs_rise = 0;
      obs_fall = 0;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].sw);
      check_bit($sformatf("vec%0d_level", i), db_level, vecs[i].exp_level);
      check_int($sformatf("vec%0d_rise", i), obs_rise, vecs[i].exp_rise);
`ifdef BTN_DEBOUNCER_FALL_TICK_EN
      check_int($sformatf("vec%0d_fall", i), obs_fall, vecs[i].exp_fall);
`endif
    end

    // Asynchronous reset from a debounced high level, released with sw low.
    async_reset_check("async_hi");
    repeat (2) step(1'b0);
    release_reset();
    repeat (12) step(1'b0);
    check_bit("hi_rst_level", db_level, 1'b0);
    check_int("hi_rst_ticks", obs_rise, 0);

    // Reset in the 4th cycle of WAIT1 aborts the interval with no pulse.
    obs_rise = 0;
    repeat (6) step(1'b1);
    check_int("wait1_state", int'(dbg_state), 1);
    async_reset_check("async_wait1");
    repeat (2) step(1'b0);
    release_reset();
    repeat (20) step(1'b0);
    check_int("wait1_abort_ticks", obs_rise, 0);
    check_bit("wait1_abort_level", db_level, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
